// File: rtl/mac_timestep_scheduler.sv
// mac_timestep_scheduler: spike FIFO plus timestep controller that drives
// the shared set / clear / source-address lines of the MAC array.
module mac_timestep_scheduler #(
    parameter int                ADDR_W       = 12,
    parameter int                FIFO_DEPTH   = 8,
    parameter int                SET_CYCLES   = 4,
    parameter int                CLEAR_CYCLES = 3,
    parameter int                ADDR_HOLD    = 2,
    parameter logic [ADDR_W-1:0] NULL_ADDR    = '1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              init_req,
    input  logic              spike_valid,
    input  logic [ADDR_W-1:0] spike_addr,
    output logic              spike_ready,
    input  logic              step_req,
    output logic              mac_set,
    output logic              mac_clear,
    output logic [ADDR_W-1:0] mac_source_address,
    output logic              mac_addr_valid,
    output logic              step_done,
    output logic              step_overrun,
    output logic              busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = 8;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_CLEAR} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q;
    logic [TW-1:0]     tmr_q;
    logic              slot_q;
    logic [TW-1:0]     slot_cnt_q;
    logic              drain_q;
    logic [CW-1:0]     drain_cnt_q;
    logic              pend_q;
    logic              set_q, clr_q, vld_q, done_q, ovr_q;
    logic [ADDR_W-1:0] addr_q;

    logic          in_run, in_clr, full, push, pop;
    logic          slot_free, cap, drn, go_clear, ovr_d;
    logic [CW-1:0] rem;

    assign in_run      = state_q == S_RUN;
    assign in_clr      = state_q == S_CLEAR;
    assign full        = cnt_q == CW'(FIFO_DEPTH);
    assign spike_ready = !full && state_q != S_INIT;
    assign push        = spike_valid && spike_ready;
    // a slot in its gap cycle ends at this edge, so the next pop may start
    assign slot_free   = !slot_q || slot_cnt_q == TW'(ADDR_HOLD);
    // a pending request from CLEAR is serviced like a fresh step_req
    assign cap         = in_run && !init_req && (pend_q || (step_req && !drain_q));
    assign drn         = cap || drain_q;
    assign rem         = cap ? cnt_q : drain_cnt_q;
    assign go_clear    = in_run && !init_req && drn && rem == '0 && slot_free;
    assign pop         = in_run && !init_req && slot_free && cnt_q != '0
                         && !(drn && rem == '0);
    assign ovr_d       = step_req && !init_req
                         && ((in_run && (drain_q || pend_q)) || (in_clr && pend_q));
    assign busy        = state_q != S_IDLE
                         && (!in_run || cnt_q != '0 || slot_q || pend_q || drain_q);

    assign mac_set            = set_q;
    assign mac_clear          = clr_q;
    assign mac_source_address = addr_q;
    assign mac_addr_valid     = vld_q;
    assign step_done          = done_q;
    assign step_overrun       = ovr_q;

    // FIFO storage: data only, pointers carry validity
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= spike_addr;
    end

    // FIFO pointers and occupancy; init discards everything queued
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (init_req) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // timestep bookkeeping: pending request and spikes left to drain
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend_q      <= 1'b0;
            drain_q     <= 1'b0;
            drain_cnt_q <= '0;
        end else if (init_req) begin
            pend_q      <= 1'b0;
            drain_q     <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            if (in_clr && step_req && !pend_q) pend_q <= 1'b1;
            else if (cap) pend_q <= 1'b0;
            drain_q     <= drn && !go_clear;
            drain_cnt_q <= (pop && drn) ? rem - CW'(1) : rem;
        end
    end

    // controller FSM with registered MAC-array outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            slot_q     <= 1'b0;
            slot_cnt_q <= '0;
            set_q      <= 1'b0;
            clr_q      <= 1'b0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            addr_q     <= NULL_ADDR;
        end else begin
            done_q <= 1'b0;
            ovr_q  <= ovr_d;
            if (init_req) begin
                state_q    <= S_INIT;
                tmr_q      <= '0;
                set_q      <= 1'b1;
                clr_q      <= 1'b0;
                vld_q      <= 1'b0;
                addr_q     <= NULL_ADDR;
                slot_q     <= 1'b0;
                slot_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: state_q <= S_IDLE;
                    S_INIT: begin
                        if (tmr_q == TW'(SET_CYCLES - 1)) begin
                            state_q <= S_RUN;
                            set_q   <= 1'b0;
                        end else begin
                            tmr_q <= tmr_q + TW'(1);
                        end
                    end
                    S_RUN: begin
                        if (go_clear) begin
                            state_q <= S_CLEAR;
                            clr_q   <= 1'b1;
                            tmr_q   <= '0;
                            slot_q  <= 1'b0;
                        end else if (pop) begin
                            slot_q     <= 1'b1;
                            slot_cnt_q <= '0;
                            addr_q     <= mem_q[rd_q];
                            vld_q      <= 1'b1;
                        end else if (slot_q) begin
                            if (slot_cnt_q == TW'(ADDR_HOLD)) begin
                                slot_q <= 1'b0;
                            end else begin
                                slot_cnt_q <= slot_cnt_q + TW'(1);
                                if (slot_cnt_q == TW'(ADDR_HOLD - 1)) begin
                                    addr_q <= NULL_ADDR;
                                    vld_q  <= 1'b0;
                                end
                            end
                        end
                    end
                    S_CLEAR: begin
                        if (tmr_q == TW'(CLEAR_CYCLES - 1)) begin
                            state_q <= S_RUN;
                            clr_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            tmr_q <= tmr_q + TW'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule
